// File: rtl/frame_tx_seq.sv
// frame_tx_seq: feeds a latched multi-byte frame, MSB byte first, plus an optional checksum byte, to a UART TX core
module frame_tx_seq #(
    parameter int NUM_BYTES  = 3,
    parameter int CHKSUM_EN  = 0,
    parameter int GAP_CYCLES = 0,
    localparam int TOTAL     = NUM_BYTES + CHKSUM_EN,
    localparam int IW        = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   snd_frm,
    input  logic [8*NUM_BYTES-1:0] frm_data,
    input  logic                   tx_done,
    output logic                   trmt,
    output logic [7:0]             tx_data,
    output logic [IW-1:0]          byte_idx,
    output logic                   busy,
    output logic                   frm_cmplt
);
    localparam int CW = $clog2(TOTAL + 1);
    typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;
    state_t                 state;
    logic [8*NUM_BYTES-1:0] sreg;
    logic [CW-1:0]          cnt;
    logic [7:0]             acc, gcnt, top, nxt_byte;
    logic                   last, issue;
    assign top      = sreg[8*NUM_BYTES-1 -: 8];
    assign nxt_byte = (CHKSUM_EN != 0 && cnt == CW'(NUM_BYTES)) ? ~acc : top;
    assign last     = cnt == CW'(TOTAL);
    assign issue    = state == SEND || (state == GAP && gcnt == 8'd0) ||
                      (state == WAIT && tx_done && !last && GAP_CYCLES == 0);
    // checksum accumulates from the shifted-out latched bytes, so live frm_data never matters after acceptance
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            sreg      <= '0;
            cnt       <= '0;
            acc       <= '0;
            gcnt      <= '0;
            trmt      <= 1'b0;
            tx_data   <= '0;
            byte_idx  <= '0;
            busy      <= 1'b0;
            frm_cmplt <= 1'b0;
        end else begin
            trmt <= 1'b0;
            if (issue) begin
                trmt      <= 1'b1;
                tx_data   <= nxt_byte;
                byte_idx  <= cnt[IW-1:0];
                cnt       <= cnt + 1'b1;
                acc       <= acc + top;
                sreg      <= sreg << 8;
                busy      <= 1'b1;
                frm_cmplt <= 1'b0;
                state     <= WAIT;
            end else
                case (state)
                    IDLE: if (snd_frm) begin
                        sreg  <= frm_data;
                        cnt   <= '0;
                        acc   <= '0;
                        state <= SEND;
                    end
                    WAIT: if (tx_done) begin
                        if (last) begin
                            frm_cmplt <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            gcnt  <= 8'(GAP_CYCLES - 1);
                            state <= GAP;
                        end
                    end
                    GAP: gcnt <= gcnt - 1'b1;
                    default: ;
                endcase
        end
endmodule

// File: tb/tb_frame_tx_seq.sv
// tb_frame_tx_seq: drives three frame_tx_seq configurations and compares against a byte-list frame model
module tb_frame_tx_seq;
    logic        clk = 1'b0;
    logic        rst_n, snd, done;
    logic [23:0] frm;
    int          sel;
    int          checks = 0, failures = 0;
    always #5 clk = ~clk;

    logic       snd_a, snd_b, snd_c, done_a, done_b, done_c;
    logic       trmt_a, trmt_b, trmt_c, busy_a, busy_b, busy_c, cmplt_a, cmplt_b, cmplt_c;
    logic [7:0] txd_a, txd_b, txd_c;
    logic [1:0] idx_a, idx_b;
    logic [0:0] idx_c;
    assign snd_a  = snd && sel == 0;
    assign snd_b  = snd && sel == 1;
    assign snd_c  = snd && sel == 2;
    assign done_a = done && sel == 0;
    assign done_b = done && sel == 1;
    assign done_c = done && sel == 2;

    frame_tx_seq #(.NUM_BYTES(3), .CHKSUM_EN(0), .GAP_CYCLES(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .snd_frm(snd_a), .frm_data(frm), .tx_done(done_a),
        .trmt(trmt_a), .tx_data(txd_a), .byte_idx(idx_a), .busy(busy_a), .frm_cmplt(cmplt_a));
    frame_tx_seq #(.NUM_BYTES(3), .CHKSUM_EN(1), .GAP_CYCLES(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .snd_frm(snd_b), .frm_data(frm), .tx_done(done_b),
        .trmt(trmt_b), .tx_data(txd_b), .byte_idx(idx_b), .busy(busy_b), .frm_cmplt(cmplt_b));
    frame_tx_seq #(.NUM_BYTES(1), .CHKSUM_EN(0), .GAP_CYCLES(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .snd_frm(snd_c), .frm_data(frm[7:0]), .tx_done(done_c),
        .trmt(trmt_c), .tx_data(txd_c), .byte_idx(idx_c), .busy(busy_c), .frm_cmplt(cmplt_c));

    logic       trmt_v, busy_v, cmplt_v;
    logic [7:0] txd_v;
    logic [3:0] idx_v;
    always_comb begin
        trmt_v  = sel == 0 ? trmt_a : sel == 1 ? trmt_b : trmt_c;
        busy_v  = sel == 0 ? busy_a : sel == 1 ? busy_b : busy_c;
        cmplt_v = sel == 0 ? cmplt_a : sel == 1 ? cmplt_b : cmplt_c;
        txd_v   = sel == 0 ? txd_a : sel == 1 ? txd_b : txd_c;
        idx_v   = sel == 0 ? {2'b0, idx_a} : sel == 1 ? {2'b0, idx_b} : {3'b0, idx_c};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Expected frame = payload bytes MSB first, then ~sum when the checksum is enabled
    task automatic run_frame(input logic [23:0] d, input int dl, input bit noise, input bit spur);
        int         nb, gp;
        logic [7:0] q[$];
        logic [7:0] sum;
        nb  = sel == 2 ? 1 : 3;
        gp  = sel == 1 ? 4 : 0;
        sum = 8'd0;
        for (int i = 0; i < nb; i++) begin
            q.push_back(d[8*(nb-1-i) +: 8]);
            sum += d[8*(nb-1-i) +: 8];
        end
        if (sel == 1) q.push_back(~sum);
        snd = 1'b1; frm = d; tick;
        snd = 1'b0; frm = 24'($urandom);
        chk("accept_no_trmt", trmt_v, 0);
        tick;
        for (int k = 0; k < q.size(); k++) begin
            chk("trmt", trmt_v, 1);
            chk("tx_data", txd_v, q[k]);
            chk("byte_idx", idx_v, k);
            chk("busy", busy_v, 1);
            chk("cmplt_clr", cmplt_v, 0);
            for (int j = 0; j < dl; j++) begin
                snd = noise && k == 1 && j == 0;
                tick;
                snd = 1'b0;
                chk("trmt_pulse", trmt_v, 0);
                chk("tx_data_hold", txd_v, q[k]);
            end
            done = 1'b1;
            snd  = noise && k == q.size() - 1;
            tick;
            done = 1'b0; snd = 1'b0;
            if (k == q.size() - 1) begin
                chk("cmplt", cmplt_v, 1);
                chk("busy_end", busy_v, 0);
                chk("trmt_end", trmt_v, 0);
                tick;
                chk("no_queue", trmt_v, 0);
                chk("idle_busy", busy_v, 0);
            end else
                for (int g = 0; g < gp; g++) begin
                    chk("gap_quiet", trmt_v, 0);
                    chk("gap_busy", busy_v, 1);
                    done = spur && g == 1;
                    tick;
                    done = 1'b0;
                end
        end
    endtask

    initial begin
        logic [7:0] b;
        rst_n = 1'b0; snd = 1'b0; done = 1'b0; frm = '0; sel = 0;
        repeat (2) tick;
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            chk("rst_trmt", trmt_v, 0);
            chk("rst_txd", txd_v, 0);
            chk("rst_idx", idx_v, 0);
            chk("rst_busy", busy_v, 0);
            chk("rst_cmplt", cmplt_v, 0);
        end
        sel = 0;
        tick;
        rst_n = 1'b1;
        tick;
        run_frame(24'hA5_3C_0F, 1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) run_frame(24'($urandom), int'($urandom_range(1, 5)), 1'b1, 1'b0);
        done = 1'b1; tick; done = 1'b0; tick;
        chk("idle_done_trmt", trmt_v, 0);
        chk("idle_done_cmplt", cmplt_v, 1);
        chk("idle_done_busy", busy_v, 0);
        // abort two cycles after the second trmt
        snd = 1'b1; frm = 24'($urandom); tick;
        snd = 1'b0; tick;
        chk("abort_trmt1", trmt_v, 1);
        tick;
        done = 1'b1; tick; done = 1'b0;
        chk("abort_trmt2", trmt_v, 1);
        chk("abort_idx2", idx_v, 1);
        tick; tick;
        rst_n = 1'b0; #1;
        chk("abort_trmt", trmt_v, 0);
        chk("abort_txd", txd_v, 0);
        chk("abort_idx", idx_v, 0);
        chk("abort_busy", busy_v, 0);
        chk("abort_cmplt", cmplt_v, 0);
        tick;
        done = 1'b1; tick; done = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("post_abort_trmt", trmt_v, 0);
            chk("post_abort_busy", busy_v, 0);
        end
        run_frame(24'($urandom), 2, 1'b0, 1'b0);
        sel = 1;
        run_frame(24'hA5_3C_0F, 10, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) run_frame(24'($urandom), int'($urandom_range(1, 12)), 1'b1, 1'b1);
        sel = 2;
        b = 8'($urandom);
        frm = {16'h0, b};
        snd = 1'b1; tick; tick;
        for (int f = 0; f < 3; f++) begin
            chk("b2b_trmt", trmt_v, 1);
            chk("b2b_txd", txd_v, b);
            chk("b2b_idx", idx_v, 0);
            chk("b2b_cmplt_clr", cmplt_v, 0);
            tick;
            chk("b2b_pulse", trmt_v, 0);
            done = 1'b1;
            if (f == 2) snd = 1'b0;
            tick;
            done = 1'b0;
            chk("b2b_cmplt", cmplt_v, 1);
            chk("b2b_busy", busy_v, 0);
            tick;
            chk("b2b_cmplt_hold", cmplt_v, 1);
            chk("b2b_gap_trmt", trmt_v, 0);
            tick;
        end
        chk("b2b_stop_trmt", trmt_v, 0);
        chk("b2b_stop_busy", busy_v, 0);
        for (int i = 0; i < 2; i++) run_frame(24'($urandom), int'($urandom_range(1, 4)), 1'b1, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
